// File: rtl/booth_mult_arbiter_if.sv
// booth_mult_arbiter_if: requester, response and shared-multiplier signals of the multiplier arbiter
interface booth_arb_if #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [16*NREQ-1:0] req_a;
  logic [16*NREQ-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [31:0]        rsp_result;
  logic               rsp_err;
  logic               mul_start;
  logic [15:0]        mul_a;
  logic [15:0]        mul_b;
  logic               mul_done;
  logic [31:0]        mul_result;
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, mul_done, mul_result,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err, mul_start, mul_a, mul_b
  );
  modport master (
    output req_valid, req_a, req_b, rsp_ready, mul_done, mul_result,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err, mul_start, mul_a, mul_b
  );
endinterface

// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter: round-robin arbiter sharing one iterative multiplier among NREQ requesters
// Define BOOTH_ARB_TIMEOUT_EN to abort WAIT after TIMEOUT cycles with rsp_err=1.
module booth_mult_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = $clog2(NREQ),
  parameter int TIMEOUT = 64
) (
  input  logic      clk,
  input  logic      rst,
  booth_arb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t         r_state, w_next;
  logic [IDW-1:0] r_last, r_id, w_grant;
  logic           w_any, w_timeout;
  logic [15:0]    r_a, r_b;
  logic [31:0]    r_result;
  logic           r_err;
  // Descending scan so the requester closest after r_last is assigned last and wins
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (bus.req_valid[(int'(r_last) + k) % NREQ]) begin
        w_any   = 1'b1;
        w_grant = IDW'((int'(r_last) + k) % NREQ);
      end
    end
  end
`ifdef BOOTH_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else     r_cnt <= (r_state == WAIT) ? r_cnt + 1'b1 : '0;
  assign w_timeout = (r_state == WAIT) && !bus.mul_done && (r_cnt == CW'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_any ? ISSUE : IDLE;
      ISSUE:   w_next = WAIT;
      WAIT:    w_next = (bus.mul_done || w_timeout) ? RESP : WAIT;
      RESP:    w_next = bus.rsp_ready ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_last   <= IDW'(NREQ - 1);
      r_id     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_any) begin
        r_id <= w_grant;
        r_a  <= bus.req_a[w_grant*16 +: 16];
        r_b  <= bus.req_b[w_grant*16 +: 16];
      end
      if (r_state == WAIT && bus.mul_done) begin
        r_result <= bus.mul_result;
        r_err    <= 1'b0;
      end else if (w_timeout) begin
        r_result <= '0;
        r_err    <= 1'b1;
      end
      if (r_state == RESP && bus.rsp_ready) r_last <= r_id;
    end
  end
  // req_ready is gated by rst so it reads 0 while reset is held, not just after
  assign bus.req_ready  = (r_state == IDLE && w_any && !rst) ? NREQ'(1) << w_grant : '0;
  assign bus.mul_start  = (r_state == ISSUE);
  assign bus.mul_a      = r_a;
  assign bus.mul_b      = r_b;
  assign bus.rsp_valid  = (r_state == RESP);
  assign bus.rsp_id     = r_id;
  assign bus.rsp_result = r_result;
  assign bus.rsp_err    = r_err;
endmodule

// File: doc/booth_mult_arbiter.md
BOOTH_MULT_ARBITER -- requirements
Module: booth_mult_arbiter

Interface
REQ-001 Parameter NREQ, 4, number of requesters sharing one multiplier (2..8).
REQ-002 Parameter IDW, $clog2(NREQ), width of the requester ID.
REQ-003 Parameter TIMEOUT, 64, maximum cycles in WAIT before abort (used only with the macro in REQ-029).
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 req_valid  in  NREQ  per-requester operation request.
REQ-007 req_ready  out  NREQ  per-requester accept, one-hot or zero.
REQ-008 req_a  in  16*NREQ  signed multiplicand, slice i belongs to requester i.
REQ-009 req_b  in  16*NREQ  signed multiplier, slice i belongs to requester i.
REQ-010 rsp_valid  out  1  result available.
REQ-011 rsp_ready  in  1  consumer accepts the result.
REQ-012 rsp_id  out  IDW  requester that owns the result.
REQ-013 rsp_result  out  32  signed product.
REQ-014 rsp_err  out  1  result aborted by timeout; rsp_result is 0 when set.
REQ-015 mul_start  out  1  single-cycle start pulse to the shared iterative multiplier.
REQ-016 mul_a, mul_b  out  16 each  operands to the multiplier.
REQ-017 mul_done  in  1  multiplier completion pulse.
REQ-018 mul_result  in  32  multiplier product, valid while mul_done=1.

Function
REQ-019 FSM states IDLE, ISSUE, WAIT, RESP; one operation in flight at a time.
REQ-020 IDLE: when any req_valid=1, grant the first set bit searching round-robin from (last_grant+1) mod NREQ; in the same cycle, drive req_ready[grant]=1 combinationally, latch the operands, latch grant as the owner ID, and go to ISSUE.
REQ-021 req_ready=0 in every state other than IDLE; a requester whose valid drops before its grant is never served.
REQ-022 ISSUE: mul_start=1 for exactly one cycle; go to WAIT. mul_a/mul_b hold the latched operands from ISSUE through WAIT.
REQ-023 WAIT: mul_done is sampled only in WAIT; mul_done in any other state is ignored. On mul_done=1, capture mul_result into rsp_result, set rsp_err=0, and go to RESP.
REQ-024 RESP: rsp_valid=1; rsp_id, rsp_result and rsp_err are stable until rsp_ready=1. On rsp_valid&rsp_ready, update last_grant to the owner ID and go to IDLE.
REQ-025 Latency: an accept in cycle T gives mul_start in T+1. If mul_done arrives in T+1+L, rsp_valid rises in T+2+L. Back-to-back operations: the next accept is no earlier than the cycle after the response handshake.
REQ-026 Fairness: with all requesters valid continuously, grants rotate 0,1,...,NREQ-1,0. No requester waits more than NREQ-1 operations.
REQ-027 Products are full 32-bit signed values passed through unmodified. The block performs no arithmetic on data.

Reset
REQ-028 rst=1 forces IDLE, last_grant=NREQ-1 (so requester 0 wins first), and all outputs to 0, including mul_start, mul_a, mul_b, rsp_*, and req_ready. Reset mid-operation drops the in-flight operation without a response; the multiplier shares the same rst.

Configuration
REQ-029 Macro BOOTH_ARB_TIMEOUT_EN defined: a WAIT cycle counter is cleared on entry to WAIT. If it reaches TIMEOUT with no mul_done, go to RESP with rsp_err=1 and rsp_result=0; a later stray mul_done is ignored.
REQ-030 Macro BOOTH_ARB_TIMEOUT_EN undefined: no counter; WAIT exits only on mul_done; rsp_err is tied to 0.

Verification
REQ-031 Single request: req_valid=0001, a=-7, b=300, done 8 cycles after start -> one mul_start pulse with mul_a=-7, mul_b=300; rsp_valid with rsp_id=0 and rsp_result=-2100, arriving 10 cycles after accept.
REQ-032 All four requesters valid for 8 operations, rsp_ready=1 -> grant order 0,1,2,3,0,1,2,3; each rsp_id matches its operands (e.g. 0x8000*0x8000 -> 0x40000000).
REQ-033 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_id and rsp_result stay stable, req_ready stays 0000, and no new mul_start is issued.
REQ-034 rst asserted in WAIT, then released -> all outputs are 0 and the state is IDLE; the pending product is never reported; the next grant goes to requester 0.
REQ-035 With BOOTH_ARB_TIMEOUT_EN defined and TIMEOUT=64, mul_done withheld -> rsp_valid after 64 WAIT cycles with rsp_err=1 and rsp_result=0; a stray mul_done injected in IDLE or RESP causes no state change.
